// File: rtl/fir_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the FIR sequencer, input FIFO,
// sample register file, coefficient memory and MAC.
interface fir_seq_ctrl_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 5
);
    logic                     en;
    logic                     fifo_empty;
    logic                     fifo_ren;
    logic signed [WIDTH-1:0]  fifo_dout;
    logic                     rf_wen;
    logic [ADDR_W-1:0]        rf_waddr;
    logic signed [WIDTH-1:0]  rf_wdata;
    logic [ADDR_W-1:0]        rf_raddr;
    logic [ADDR_W-1:0]        cm_raddr;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     mac_last;
    logic                     y_load;
    logic                     busy;

    modport master (
        input  en, fifo_empty, fifo_dout,
        output fifo_ren, rf_wen, rf_waddr, rf_wdata, rf_raddr, cm_raddr,
               mac_clr, mac_en, mac_last, y_load, busy
    );

    modport slave (
        output en, fifo_empty, fifo_dout,
        input  fifo_ren, rf_wen, rf_waddr, rf_wdata, rf_raddr, cm_raddr,
               mac_clr, mac_en, mac_last, y_load, busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: zero-fills the delay line, pops FIFO samples into it and issues NTAPS MAC steps.
// Optional FIR_SEQ_SAMPLE_CNT_EN adds sample_cnt and ovr_flag status outputs.
module fir_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NTAPS  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk2,
    input  logic                 rstn2,
    fir_seq_ctrl_if.master       bus
`ifdef FIR_SEQ_SAMPLE_CNT_EN
    ,
    output logic [15:0]          sample_cnt,
    output logic [0:0]           ovr_flag
`endif
);

    typedef enum logic [2:0] {StInit, StIdle, StCapt, StMac, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] KLast     = ADDR_W'(NTAPS - 1);
    localparam logic [1:0]        DrainLast = 2'(RD_LAT - 1);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0]         wptr_q, wptr_d;
    logic [ADDR_W-1:0]         k_q, k_d;
    logic [1:0]                drain_q, drain_d;
    // Per stage: {valid, first, last}
    logic [RD_LAT-1:0][2:0]    pipe_q, pipe_d;
    logic [2:0]                issue;

    logic                      fifo_ren;
    logic                      rf_wen;
    logic [ADDR_W-1:0]         rf_waddr;
    logic signed [WIDTH-1:0]   rf_wdata;
    logic [ADDR_W-1:0]         rf_raddr;
    logic [ADDR_W-1:0]         cm_raddr;
    logic                      y_load;
    logic                      busy;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wptr_d     = wptr_q;
        k_d        = k_q;
        drain_d    = drain_q;
        issue      = 3'b000;
        fifo_ren   = 1'b0;
        rf_wen     = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        rf_raddr   = '0;
        cm_raddr   = '0;
        y_load     = 1'b0;
        busy       = 1'b1;

        unique case (state_q)
            StInit: begin
                rf_wen     = 1'b1;
                rf_waddr   = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                busy = 1'b0;
                if (bus.en && !bus.fifo_empty) begin
                    fifo_ren = 1'b1;
                    state_d  = StCapt;
                end
            end
            StCapt: begin
                rf_wen   = 1'b1;
                rf_waddr = wptr_q;
                rf_wdata = bus.fifo_dout;
                k_d      = '0;
                state_d  = StMac;
            end
            StMac: begin
                // Newest sample first, walking back through the circular delay line.
                rf_raddr = wptr_q - k_q;
                cm_raddr = k_q;
                issue    = {1'b1, k_q == '0, k_q == KLast};
                k_d      = k_q + 1'b1;
                if (k_q == KLast) begin
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                y_load  = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    // Delays the issued MAC control to line up with the memory read data.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            wptr_q     <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wptr_q     <= wptr_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            pipe_q     <= pipe_d;
        end
    end

    assign bus.fifo_ren = fifo_ren;
    assign bus.rf_wen   = rf_wen;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.rf_raddr = rf_raddr;
    assign bus.cm_raddr = cm_raddr;
    assign bus.mac_en   = pipe_q[RD_LAT-1][2];
    assign bus.mac_clr  = pipe_q[RD_LAT-1][1];
    assign bus.mac_last = pipe_q[RD_LAT-1][0];
    assign bus.y_load   = y_load;
    assign bus.busy     = busy;

`ifdef FIR_SEQ_SAMPLE_CNT_EN
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        ovr_d        = ovr_q;
        if (state_q == StDone) begin
            sample_cnt_d = sample_cnt_q + 16'd1;
            // Backlog still waiting when a result completes.
            if (!bus.fifo_empty) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            sample_cnt_q <= '0;
            ovr_q        <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            ovr_q        <= ovr_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign ovr_flag   = ovr_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl at default parameters; per-cycle output log checked
// against hand-derived cycle offsets and addresses.
module tb_fir_seq_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NTAPS  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned RD_LAT = 1;
    localparam int          LOGN   = 4096;

    logic clk2  = 1'b0;
    logic rstn2 = 1'b0;

    fir_seq_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

`ifdef FIR_SEQ_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
    logic [0:0]  ovr_flag;
`endif

    fir_seq_ctrl #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk2      (clk2),
        .rstn2     (rstn2),
        .bus       (bus)
`ifdef FIR_SEQ_SAMPLE_CNT_EN
        ,
        .sample_cnt(sample_cnt),
        .ovr_flag  (ovr_flag)
`endif
    );

    always #5 clk2 = ~clk2;

    int cyc = 0;
    always @(posedge clk2) cyc++;

    logic              log_ren  [LOGN];
    logic              log_wen  [LOGN];
    logic [ADDR_W-1:0] log_waddr[LOGN];
    logic [WIDTH-1:0]  log_wdata[LOGN];
    logic [ADDR_W-1:0] log_raddr[LOGN];
    logic [ADDR_W-1:0] log_craddr[LOGN];
    logic              log_men  [LOGN];
    logic              log_mclr [LOGN];
    logic              log_mlast[LOGN];
    logic              log_yl   [LOGN];
    logic              log_busy [LOGN];

    always @(negedge clk2) begin
        if (cyc < LOGN) begin
            log_ren[cyc]    = bus.fifo_ren;
            log_wen[cyc]    = bus.rf_wen;
            log_waddr[cyc]  = bus.rf_waddr;
            log_wdata[cyc]  = bus.rf_wdata;
            log_raddr[cyc]  = bus.rf_raddr;
            log_craddr[cyc] = bus.cm_raddr;
            log_men[cyc]    = bus.mac_en;
            log_mclr[cyc]   = bus.mac_clr;
            log_mlast[cyc]  = bus.mac_last;
            log_yl[cyc]     = bus.y_load;
            log_busy[cyc]   = bus.busy;
        end
    end

    // FIFO model: registered empty flag, data valid the cycle after a pop.
    int               n_push = 0;
    int               n_pop  = 0;
    logic [WIDTH-1:0] fdata[64];

    initial begin
        logic ren_s;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        forever begin
            @(negedge clk2);
            ren_s = bus.fifo_ren;
            @(posedge clk2);
            #2;
            if (ren_s) begin
                bus.fifo_dout = fdata[n_pop];
                n_pop++;
            end
            bus.fifo_empty = (n_pop >= n_push);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic wait_pop(output int pc);
        pc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk2);
            if (bus.fifo_ren === 1'b1) begin
                pc = cyc;
                break;
            end
        end
        if (pc < 0) begin
            check("pop_timeout", 32'd0, 32'd1);
            pc = cyc;
        end
    endtask

    function automatic int count_ren(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (log_ren[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_yl(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (log_yl[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [ADDR_W-1:0] back(input int base, input int k);
        return ADDR_W'((base + 32 - k) % 32);
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, p, q, n;
        bus.en = 1'b0;
        rstn2  = 1'b0;
        repeat (2) tick();

        // Reset state
        @(negedge clk2);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_ren", bus.fifo_ren, 1'b0);
        check("rst_mac_en", bus.mac_en, 1'b0);
        check("rst_y_load", bus.y_load, 1'b0);

        // Init sweep
        tick();
        rstn2 = 1'b1;
        rel   = cyc;
        repeat (45) tick();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("init_wen[%0d]", i), log_wen[rel+i], 1'b1);
            check($sformatf("init_waddr[%0d]", i), log_waddr[rel+i], i);
            check($sformatf("init_wdata[%0d]", i), log_wdata[rel+i], 0);
            check($sformatf("init_ren[%0d]", i), log_ren[rel+i], 1'b0);
        end
        for (int i = 32; i < 44; i++) begin
            check($sformatf("idle_busy[%0d]", i), log_busy[rel+i], 1'b0);
            check($sformatf("idle_ren[%0d]", i), log_ren[rel+i], 1'b0);
            check($sformatf("idle_wen[%0d]", i), log_wen[rel+i], 1'b0);
        end

        // Single sample 0x1234
        fdata[0] = 16'h1234;
        bus.en   = 1'b1;
        n_push   = 1;
        wait_pop(p);
        repeat (45) tick();
        check("s1_capt_wen", log_wen[p+1], 1'b1);
        check("s1_capt_addr", log_waddr[p+1], 0);
        check("s1_capt_data", log_wdata[p+1], 16'h1234);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("s1_raddr[%0d]", k), log_raddr[p+2+k], back(0, k));
            check($sformatf("s1_craddr[%0d]", k), log_craddr[p+2+k], k);
            check($sformatf("s1_mac_en[%0d]", k), log_men[p+3+k], 1'b1);
            check($sformatf("s1_mac_clr[%0d]", k), log_mclr[p+3+k], k == 0);
            check($sformatf("s1_mac_last[%0d]", k), log_mlast[p+3+k], k == 31);
        end
        check("s1_mac_en_pre", log_men[p+2], 1'b0);
        check("s1_mac_en_post", log_men[p+35], 1'b0);
        check("s1_y_load", log_yl[p+35], 1'b1);
        check("s1_y_load_cnt", count_yl(p, p+44), 1);
        check("s1_ren_cnt", count_ren(p, p+44), 1);
        check("s1_busy_done", log_busy[p+35], 1'b1);
        check("s1_idle", log_busy[p+36], 1'b0);

        // Four queued samples after a fresh reset
        bus.en = 1'b0;
        rstn2  = 1'b0;
        tick();
        rstn2 = 1'b1;
        repeat (40) tick();
        for (int i = 1; i <= 4; i++) fdata[i] = WIDTH'(16'h0a00 + i);
        bus.en = 1'b1;
        n_push = n_push + 4;
        wait_pop(p);
        repeat (4 * 36 + 10) tick();
        for (int s = 0; s < 4; s++) begin
            check($sformatf("q4_pop[%0d]", s), log_ren[p+36*s], 1'b1);
            check($sformatf("q4_waddr[%0d]", s), log_waddr[p+36*s+1], s);
            check($sformatf("q4_wdata[%0d]", s), log_wdata[p+36*s+1], fdata[1+s]);
            check($sformatf("q4_y_load[%0d]", s), log_yl[p+36*s+35], 1'b1);
        end
        check("q4_ren_cnt", count_ren(p, p + 4 * 36 + 8), 4);
        check("q4_s4_raddr0", log_raddr[p+108+2], 3);
        check("q4_s4_raddr1", log_raddr[p+108+3], 2);
`ifdef FIR_SEQ_SAMPLE_CNT_EN
        check("q4_sample_cnt", sample_cnt, 4);
        check("q4_ovr_flag", ovr_flag, 1'b1);
`endif

        // 33 samples wrap the write pointer
        bus.en = 1'b0;
        rstn2  = 1'b0;
        tick();
        rstn2 = 1'b1;
        repeat (40) tick();
        for (int i = 5; i <= 37; i++) fdata[i] = WIDTH'(16'h0100 + i);
        bus.en = 1'b1;
        n_push = n_push + 33;
        wait_pop(p);
        repeat (33 * 36 + 10) tick();
        check("w33_s31_waddr", log_waddr[p+36*31+1], 31);
        check("w33_pop", log_ren[p+1152], 1'b1);
        check("w33_waddr", log_waddr[p+1153], 0);
        check("w33_wdata", log_wdata[p+1153], fdata[37]);
        check("w33_raddr0", log_raddr[p+1154], 0);
        check("w33_raddr1", log_raddr[p+1155], 31);
        check("w33_raddr31", log_raddr[p+1185], 1);
        check("w33_y_load", log_yl[p+1187], 1'b1);
        check("w33_ren_cnt", count_ren(p, p + 33 * 36 + 8), 33);

        // en dropped mid-sample
        fdata[38] = 16'h7fff;
        fdata[39] = 16'h8000;
        n_push    = n_push + 2;
        wait_pop(p);
        repeat (12) @(posedge clk2);
        #1;
        bus.en = 1'b0;
        repeat (60) tick();
        check("en_waddr", log_waddr[p+1], 1);
        check("en_wdata", log_wdata[p+1], 16'h7fff);
        check("en_mac_last", log_mlast[p+34], 1'b1);
        check("en_y_load", log_yl[p+35], 1'b1);
        check("en_no_pop", count_ren(p + 1, p + 70), 0);
        bus.en = 1'b1;
        @(negedge clk2);
        q = cyc;
        check("en_resume_pop", bus.fifo_ren, 1'b1);

        // Reset at k=20 of the resumed sample
        repeat (22) @(posedge clk2);
        #1;
        rstn2 = 1'b0;
        @(negedge clk2);
        check("mid_rst_busy", bus.busy, 1'b1);
        check("mid_rst_mac_en", bus.mac_en, 1'b0);
        tick();
        bus.en = 1'b0;
        rstn2  = 1'b1;
        rel    = cyc;
        repeat (40) tick();
        n = count_yl(q + 22, q + 60);
        check("mid_rst_no_y_load", n, 0);
        check("mid_rst_init_wen", log_wen[rel], 1'b1);
        check("mid_rst_init_addr0", log_waddr[rel], 0);
        check("mid_rst_init_addr5", log_waddr[rel+5], 5);
`ifdef FIR_SEQ_SAMPLE_CNT_EN
        check("mid_rst_sample_cnt", sample_cnt, 0);
        check("mid_rst_ovr_flag", ovr_flag, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
